lfsr_rand_stream: RTL
=====================

// Module: lfsr_rand_stream
// PURPOSE
//  Parametrised pseudo-random number source for game/display logic. A Fibonacci LFSR
//  of configurable width and taps steps every enabled clock. Values are rejection-
//  sampled into the range 0..RANGE-1, with optional no-immediate-repeat filtering.
//  A bounded-retry fallback caps search time. Results leave on a valid/ready stream.
//  Supports runtime reseeding; successor of the fixed 4-bit/2-bit digit generator.
// PARAMETERS
//  LFSR_W     16       LFSR width in bits (>=3)
//  TAPS       16'hB400 feedback tap mask; bit i set = lfsr[i] XORed into feedback
//  SEED       16'hACE1 reset / fallback seed (must be non-zero)
//  OUT_W      2        output width (<= LFSR_W)
//  RANGE      4        legal outputs 0..RANGE-1 (2 <= RANGE <= 2**OUT_W)
//  NO_REPEAT  1        1 = never emit the same value twice in a row
//  MAX_TRIES  15       rejections tolerated before fallback value is forced (>=1)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  en          in   1        1 = LFSR steps and search proceeds; 0 = freeze everything
//  seed_load   in   1        1-cycle pulse: load seed_in into LFSR (overrides step)
//  seed_in     in   LFSR_W   seed value; all-zero replaced by SEED
//  rand_ready  in   1        consumer accepts rand_num when rand_valid&rand_ready
//  rand_valid  out  1        rand_num holds an accepted value
//  rand_num    out  OUT_W    random value, stable while rand_valid&!rand_ready
//  lfsr_state  out  LFSR_W   current LFSR contents (debug)
// BEHAVIOUR
//  Reset (async, !reset): lfsr=SEED, rand_valid=0, rand_num=0, tries=0, has_last=0,
//   last=0, state=SEARCH. Reset mid-transfer drops rand_valid immediately, no handshake.
//  LFSR: fb = ^(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb} each clk with en=1,
//   in every state. seed_load wins over step and en. If lfsr is ever all-zero, load
//   SEED next clk (lockup guard).
//  Candidate: cand = lfsr[OUT_W-1:0] (pre-step value). Legal iff cand < RANGE and
//   (!NO_REPEAT or !has_last or cand != last).
//  FSM (advances only when en=1; HOLD handshake still completes when en=0):
//   SEARCH: legal cand -> rand_num=cand, last=cand, has_last=1, tries=0, rand_valid=1,
//     ->HOLD (latency 1 clk). Illegal and tries==MAX_TRIES -> emit fallback
//     f=(last+1==RANGE)?0:last+1 (0 if !has_last), same updates, ->HOLD.
//     Otherwise tries++, stay.
//   HOLD: rand_valid=1, rand_num frozen. On valid&ready: rand_valid=0 next clk,
//     ->SEARCH. Peak throughput is therefore 1 value per 2 clks.
//  seed_load does not disturb HOLD data; it resets tries, keeps last/has_last.
//  tries width = clog2(MAX_TRIES+1); it never wraps.
// TESTING (cfg T: LFSR_W=4 TAPS=4'b1100 SEED=4'b1001 OUT_W=2 RANGE=4 NO_REPEAT=1)
//  1 cfg T, en=1, ready=1 from reset release -> lfsr 1001,0011,0110,1101,1010,0101..;
//    transfers 01 (clk1), 10 (clk3); clk5 cand 10 rejected; 01 emitted clk6; period 15.
//  2 cfg T, ready=0 for 10 clks after first valid -> rand_num held at 01, valid=1;
//    lfsr keeps stepping; ready=1 -> one transfer, valid=0 next clk.
//  3 cfg T, RANGE=3 -> cand 11 never emitted over 1000 transfers; no back-to-back repeats.
//  4 cfg T, MAX_TRIES=1, RANGE=2, force last=1 path -> after 1 rejection fallback 0 emitted.
//  5 seed_load=1 with seed_in=0 -> lfsr=SEED next clk; seed_in=4'b0110 -> lfsr=0110.
//  6 reset asserted while HOLD -> rand_valid=0, lfsr=SEED at once; first value post-release 01.

Source files
------------

// File: rtl/lfsr_rand_stream_if.sv
// Valid/ready stream carrying one bounded random value from lfsr_rand_stream.
// master = producer (the generator), slave = consumer.
interface lfsr_rand_stream_if #(
  parameter int OUT_W = 2
);
  logic             rand_valid;
  logic             rand_ready;
  logic [OUT_W-1:0] rand_num;

  modport master (output rand_valid, output rand_num, input  rand_ready);
  modport slave  (input  rand_valid, input  rand_num, output rand_ready);
endinterface

// File: rtl/lfsr_rand_stream.sv
// Fibonacci-LFSR random source: rejection-samples LFSR bits into 0..RANGE-1, with optional
// no-immediate-repeat filtering and a bounded-retry fallback, and presents values on a valid/ready stream.
module lfsr_rand_stream #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                OUT_W     = 2,
  parameter int                RANGE     = 4,
  parameter int                NO_REPEAT = 1,
  parameter int                MAX_TRIES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  output logic [LFSR_W-1:0]  lfsr_state,
  lfsr_rand_stream_if.master rs
);

  localparam int                 TRIES_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
  localparam logic [OUT_W:0]     RANGE_V   = RANGE[OUT_W:0];

  typedef enum logic {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [LFSR_W-1:0]  lfsr, lfsr_nx;
  logic [OUT_W-1:0]   num_q, num_nx;
  logic [OUT_W-1:0]   last, last_nx;
  logic               has_last, has_last_nx;
  logic [TRIES_W-1:0] tries, tries_nx;

  logic               fb;
  logic [OUT_W-1:0]   cand;
  logic               legal;
  logic [OUT_W:0]     last_inc;
  logic [OUT_W-1:0]   fallback;

  // Candidate is taken from the pre-step LFSR value, so the step and the decision share a clock.
  assign fb       = ^(lfsr & TAPS);
  assign cand     = lfsr[OUT_W-1:0];
  assign legal    = ({1'b0, cand} < RANGE_V) &&
                    ((NO_REPEAT == 0) || !has_last || (cand != last));
  assign last_inc = {1'b0, last} + (OUT_W + 1)'(1);
  assign fallback = (!has_last || last_inc == RANGE_V) ? '0 : last_inc[OUT_W-1:0];

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    num_nx      = num_q;
    last_nx     = last;
    has_last_nx = has_last;
    tries_nx    = tries;

    // Reload beats lockup recovery, which beats a normal step.
    if (seed_load)
      lfsr_nx = (seed_in == '0) ? SEED : seed_in;
    else if (lfsr == '0)
      lfsr_nx = SEED;
    else if (en)
      lfsr_nx = {lfsr[LFSR_W-2:0], fb};
    else
      lfsr_nx = lfsr;

    unique case (state)
      SEARCH: begin
        // A reseed cycle restarts the search budget instead of judging a stale candidate.
        if (!seed_load && en) begin
          if (legal || tries == TRIES_MAX) begin
            num_nx      = legal ? cand : fallback;
            last_nx     = legal ? cand : fallback;
            has_last_nx = 1'b1;
            tries_nx    = '0;
            state_nx    = HOLD;
          end else begin
            tries_nx = tries + TRIES_W'(1);
          end
        end
      end
      HOLD: begin
        // The handshake completes even while frozen so a consumer is never stalled by en.
        if (rs.rand_ready) state_nx = SEARCH;
      end
    endcase

    if (seed_load) tries_nx = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      lfsr     <= SEED;
      num_q    <= '0;
      last     <= '0;
      has_last <= 1'b0;
      tries    <= '0;
    end else begin
      state    <= state_nx;
      lfsr     <= lfsr_nx;
      num_q    <= num_nx;
      last     <= last_nx;
      has_last <= has_last_nx;
      tries    <= tries_nx;
    end
  end

  assign rs.rand_valid = (state == HOLD);
  assign rs.rand_num   = num_q;
  assign lfsr_state    = lfsr;

endmodule
